md_sequencer: RTL
=================

// Module: md_sequencer
// PURPOSE
//  Multi-cycle multiply/divide sequencer with HI/LO registers, beside the ALU in the E stage.
//  Accepts one MD op per launch, counts out a fixed latency and commits HI/LO at completion.
//  Exports busy/launch so the hazard unit can stall later MD-class instructions in D.
//  Also serves mthi/mtlo writes and mfhi/mflo reads (via hi/lo outputs).
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-low; 0 clears all state immediately
//  md_op     in   4   0000 none, 0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo; others = none
//  md_a      in   32  operand A (rs), sampled at launch/mt
//  md_b      in   32  operand B (rt), sampled at launch
//  launch    out  1   combinational: md_op is mult/multu/div/divu and state==IDLE
//  busy      out  1   registered: 1 while an op is in flight
//  md_stall  out  1   launch | busy
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset (reset==0): state=IDLE, count=0, busy=0, hi=0, lo=0, pending result=0.
//  States: IDLE, MUL, DIV. count is 4 bits wide (covers both defaults); widen it if a parameter exceeds 15.
//  IDLE + mult/multu at edge T:
//   - compute the 64-bit product: signed for mult, unsigned for multu
//   - latch it into pend_hi/pend_lo; count=MULT_CYCLES-1; go to MUL; busy=1 from T
//  IDLE + div/divu:
//   - same sequence; pend_lo=quotient, pend_hi=remainder; count=DIV_CYCLES-1; go to DIV
//   - signed div truncates toward zero; remainder takes the sign of the dividend
//   - 0x80000000 / -1: quotient 0x80000000, remainder 0
//  Divide by zero: op still occupies DIV_CYCLES busy cycles, but hi/lo are NOT updated.
//  MUL/DIV: count>0 -> count-1. count==0 -> hi/lo<=pend, state=IDLE, busy=0 at the same edge.
//  Latency: an N-cycle op gives exactly N cycles of busy=1; hi/lo are new in the cycle busy falls.
//  mthi/mtlo in IDLE: hi (or lo) <= md_a at the next edge; launch=0 for these ops.
//  Any md_op while busy is ignored (no relaunch, no mt write). The hazard unit must prevent it;
//  the bench asserts that it never happens.
//  Back-to-back: the cycle after busy falls, a new launch is accepted.
//  Reset asserted mid-op: the op is discarded and hi/lo=0; no commit after release.
//  hi/lo outputs are the registers themselves; there is no bypass of pending results.
// STRUCTURE
//  Shared package: MD_OP_* 4-bit encodings (shared with the decoder and ALU ctrl) and
//  MD_ST_IDLE/MUL/DIV state codes.
//  One sub-module: md_compute. Combinational; takes (op, a, b) and returns {pend_hi, pend_lo, div_zero}.
//  Sequencer FSM, counter and HI/LO registers stay in md_sequencer.
// TESTING
//  1. mult a=0xFFFFFFFF b=2 -> busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
//  2. multu a=0xFFFFFFFF b=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
//  3. div a=-7 (0xFFFFFFF9) b=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu with the same operands -> lo=0x7FFFFFFC, hi=1.
//  4. hi=lo=0x1234 preset via mthi/mtlo; divu b=0 -> busy 10 cycles; hi=lo=0x1234 unchanged.
//  5. Launch mult, then mtlo 0xAA during busy -> mtlo ignored, lo=product.
//     A second mult issued the cycle after busy falls launches normally.
//  6. Launch div; assert reset at busy cycle 4 -> busy=0, hi=lo=0 immediately.
//     Release reset -> no later commit; state IDLE.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer: MD op codes (also used by
// the decoder and ALU control) and the sequencer state type.
package md_sequencer_pkg;

  localparam logic [3:0] MD_OP_NONE  = 4'b0000;
  localparam logic [3:0] MD_OP_MULT  = 4'b0001;
  localparam logic [3:0] MD_OP_MULTU = 4'b0010;
  localparam logic [3:0] MD_OP_DIV   = 4'b0011;
  localparam logic [3:0] MD_OP_DIVU  = 4'b0100;
  localparam logic [3:0] MD_OP_MTHI  = 4'b0101;
  localparam logic [3:0] MD_OP_MTLO  = 4'b0110;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_MUL  = 2'd1,
    MD_ST_DIV  = 2'd2
  } md_state_e;

  // Ops that occupy the sequencer for a multi-cycle latency.
  function automatic logic md_is_launch_op(input logic [3:0] op);
    return (op == MD_OP_MULT) || (op == MD_OP_MULTU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_DIVU);
  endfunction

  function automatic logic md_is_div_op(input logic [3:0] op);
    return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair that the
// sequencer will commit once the op latency has elapsed.
module md_compute
  import md_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] pend_hi,
  output logic [31:0] pend_lo,
  output logic        div_zero
);

  logic        signed_op;
  logic        is_div;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Sign-extended 64-bit multiply yields both signed and unsigned products;
  // signed divide runs on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
  always_comb begin
    signed_op = (op == MD_OP_MULT) || (op == MD_OP_DIV);
    is_div    = md_is_div_op(op);

    a_ext = {{32{a[31] & signed_op}}, a};
    b_ext = {{32{b[31] & signed_op}}, b};
    prod  = a_ext * b_ext;

    a_neg   = signed_op & a[31];
    b_neg   = signed_op & b[31];
    a_mag   = a_neg ? (32'd0 - a) : a;
    b_mag   = b_neg ? (32'd0 - b) : b;
    divisor = (b == '0) ? 32'd1 : b_mag;
    q_mag   = a_mag / divisor;
    r_mag   = a_mag % divisor;
    quot    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem     = a_neg ? (32'd0 - r_mag) : r_mag;

    pend_hi  = is_div ? rem  : prod[63:32];
    pend_lo  = is_div ? quot : prod[31:0];
    div_zero = is_div && (b == '0);
  end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer with HI/LO registers. Launches one MD
// op from IDLE, counts out its fixed latency, then commits HI/LO.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        launch,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = ($clog2(MAX_CYCLES) > 4) ? $clog2(MAX_CYCLES) : 4;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;

  logic [31:0]      res_hi;
  logic [31:0]      res_lo;
  logic             res_dz;

  md_compute u_compute (
    .op       (md_op),
    .a        (md_a),
    .b        (md_b),
    .pend_hi  (res_hi),
    .pend_lo  (res_lo),
    .div_zero (res_dz)
  );

  // Next-state, counter, HI/LO and launch decode.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    busy_d    = busy_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    launch    = 1'b0;

    case (state_q)
      MD_ST_IDLE: begin
        if (md_is_launch_op(md_op)) begin
          launch    = 1'b1;
          busy_d    = 1'b1;
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_dz_d = res_dz;
          if (md_is_div_op(md_op)) begin
            state_d = MD_ST_DIV;
            count_d = DIV_LOAD;
          end else begin
            state_d = MD_ST_MUL;
            count_d = MULT_LOAD;
          end
        end else if (md_op == MD_OP_MTHI) begin
          hi_d = md_a;
        end else if (md_op == MD_OP_MTLO) begin
          lo_d = md_a;
        end
      end
      MD_ST_MUL, MD_ST_DIV: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end else begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = MD_ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = MD_ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counter, HI/LO and pending-result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_ST_IDLE;
      count_q   <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign busy     = busy_q;
  assign md_stall = launch | busy_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
